multicore_mem_arbiter: RTL and testbench

Parametrised memory arbiter for an N-core system: each core's icache and dcache present one memory channel apiece, and the block funnels all 2×NCORES channels onto the single RAM port with round-robin fairness across cores. It sits between the per-core caches blocks and the RAM model, replacing the fixed single-core i/d pass-through. Only one transaction is outstanding at a time. Each granted transaction is held to completion against a RAM that may stall for a variable number of cycles.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/multicore_mem_arbiter_rr_picker.sv | 36 +++
 rtl/multicore_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_multicore_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the multicore memory arbiter: RAM handshake state,
// arbiter FSM state, channel type, and a helper for index widths.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_type_t;

  // Width of an index into n items; never zero so n=1 still gets a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicore_mem_arbiter_rr_picker.sv
// rr_picker: combinational rotating priority encoder. The first requester at
// or above ptr (wrapping modulo N) wins; outputs a one-hot grant and its index.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] rot;
  logic [IW-1:0]  off;
  logic           hit;
  logic [IW:0]    sum;

  // Rotate the doubled request vector so bit k is channel (ptr+k) mod N,
  // take the lowest set bit, then map the offset back to a channel index.
  always_comb begin
    rot = {req, req} >> ptr;
    off = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        off = IW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx = hit ? sum[IW-1:0] : '0;
    gnt = hit ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// multicore_mem_arbiter: funnels each core's I and D cache channels onto one
// RAM port, one transaction outstanding, round-robin across cores with D
// beating I within a core. Optional macro CACHE_ARB_DATA_PRIORITY_EN makes any
// D request beat every I request, with the pointer advancing on D completions.
module multicore_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NCORES-1:0]              iREN,
  input  logic [NCORES-1:0][ADDR_W-1:0]  iaddr,
  output logic [NCORES-1:0]              iwait,
  output logic [NCORES-1:0][WORD_W-1:0]  iload,
  input  logic [NCORES-1:0]              dREN,
  input  logic [NCORES-1:0]              dWEN,
  input  logic [NCORES-1:0][ADDR_W-1:0]  daddr,
  input  logic [NCORES-1:0][WORD_W-1:0]  dstore,
  output logic [NCORES-1:0]              dwait,
  output logic [NCORES-1:0][WORD_W-1:0]  dload,
  output logic [ADDR_W-1:0]              ramaddr,
  output logic                           ramREN,
  output logic                           ramWEN,
  output logic [WORD_W-1:0]              ramstore,
  input  logic [WORD_W-1:0]              ramload,
  input  ramstate_t                      ramstate
);

  localparam int IW = idx_w(NCORES);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] rr_ptr, ptr_next;
  logic [IW-1:0] gnt_core, sel_core;
  arb_type_t     gnt_type, sel_type;
  logic          gnt_write;
  logic          sel_any, live_req, done, adv_ok;
  logic [NCORES-1:0] d_req;

  assign d_req = dREN | dWEN;

`ifdef CACHE_ARB_DATA_PRIORITY_EN
  logic [NCORES-1:0] d_gnt, i_gnt;
  logic [IW-1:0]     d_idx, i_idx;

  rr_picker #(.N(NCORES), .IW(IW)) u_d_pick (
    .req(d_req), .ptr(rr_ptr), .gnt(d_gnt), .idx(d_idx)
  );
  rr_picker #(.N(NCORES), .IW(IW)) u_i_pick (
    .req(iREN), .ptr(rr_ptr), .gnt(i_gnt), .idx(i_idx)
  );

  assign sel_any  = |d_gnt | |i_gnt;
  assign sel_type = (|d_gnt) ? ARB_D : ARB_I;
  assign sel_core = (|d_gnt) ? d_idx : i_idx;
  assign adv_ok   = (gnt_type == ARB_D);
`else
  logic [NCORES-1:0] core_gnt;

  rr_picker #(.N(NCORES), .IW(IW)) u_core_pick (
    .req(d_req | iREN), .ptr(rr_ptr), .gnt(core_gnt), .idx(sel_core)
  );

  assign sel_any  = |core_gnt;
  assign sel_type = (|(core_gnt & d_req)) ? ARB_D : ARB_I;
  assign adv_ok   = 1'b1;
`endif

  assign ptr_next = (gnt_core == IW'(NCORES-1)) ? '0 : gnt_core + 1'b1;

  // FSM state, latched grant and round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_core  <= '0;
      gnt_type  <= ARB_I;
      gnt_write <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_any) begin
        gnt_core  <= sel_core;
        gnt_type  <= sel_type;
        // dREN together with dWEN is served as a write.
        gnt_write <= (sel_type == ARB_D) && dWEN[sel_core];
      end
      if (done && adv_ok) rr_ptr <= ptr_next;
    end
  end

  // Next state and all outputs: RAM driven from the granted channel's live
  // inputs; a dropped request aborts without completing or advancing rr_ptr.
  always_comb begin
    state_nxt = state;
    iwait     = '1;
    dwait     = '1;
    iload     = '0;
    dload     = '0;
    ramaddr   = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramstore  = '0;
    done      = 1'b0;
    if (gnt_type == ARB_I) live_req = iREN[gnt_core];
    else                   live_req = gnt_write ? dWEN[gnt_core] : dREN[gnt_core];
    case (state)
      IDLE: if (sel_any) state_nxt = SERVE;
      SERVE: begin
        if (!live_req) begin
          state_nxt = IDLE;
        end else begin
          ramREN  = !gnt_write;
          ramWEN  = gnt_write;
          ramaddr = (gnt_type == ARB_I) ? iaddr[gnt_core] : daddr[gnt_core];
          if (gnt_type == ARB_D) ramstore = dstore[gnt_core];
          if (ramstate == ACCESS) begin
            done      = 1'b1;
            state_nxt = IDLE;
            if (gnt_type == ARB_I) begin
              iwait[gnt_core] = 1'b0;
              iload[gnt_core] = ramload;
            end else begin
              dwait[gnt_core] = 1'b0;
              dload[gnt_core] = ramload;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Bench for multicore_mem_arbiter (NCORES=2, default build): a vector table of
// request patterns with expected completion order, a scoreboard queue popped on
// each wait-low, a latency-programmable RAM responder, and hand sequences for
// abort and mid-transaction reset.
module tb_multicore_mem_arbiter;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       iREN, dREN, dWEN, iwait, dwait;
  logic [1:0][31:0] iaddr, daddr, dstore, iload, dload;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic             ramREN, ramWEN;
  ramstate_t        ramstate;

  multicore_mem_arbiter #(.NCORES(2), .ADDR_W(32), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramaddr(ramaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // Channel ids: I0=0, D0=1, I1=2, D1=3.
  typedef struct {
    logic [1:0]      ireq, dren, dwen;
    int              lat;
    bit              err;
    int              n;
    logic [3:0][1:0] ord;
  } vec_t;
  typedef struct { int ch; bit wr; } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_chk = 0, n_pass = 0;
  logic [1:0] ip = '0, drp = '0, dwp = '0;
  int   ram_lat = 0, cnt = 0;
  bit   ram_err = 0;

  localparam logic [31:0] LOAD_KEY = 32'hDEADBEEF;

  function automatic logic [31:0] addr_of(input int ch);
    int core;
    core = ch >> 1;
    return (ch % 2 == 1) ? 32'h100 + 32'h1000 * core : 32'h40 + 32'h1000 * core;
  endfunction

  function automatic logic [31:0] store_of(input int core);
    return 32'h5000_0000 + core;
  endfunction

  function automatic vec_t mk(input logic [1:0] i, d, w, input int lat, input bit err,
                              input int n, input int o0, o1, o2, o3);
    vec_t v;
    v.ireq = i; v.dren = d; v.dwen = w; v.lat = lat; v.err = err; v.n = n;
    v.ord[0] = 2'(o0); v.ord[1] = 2'(o1); v.ord[2] = 2'(o2); v.ord[3] = 2'(o3);
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Sample outputs on the falling edge; pop the scoreboard on each completion.
  task automatic monitor();
    int  lows, core;
    bit  lz, isd, w;
    sb_t e;
    lows = 0; lz = 1;
    for (int c = 0; c < 2; c++) begin
      if (iwait[c]) begin if (iload[c] != 0) lz = 0; end else lows++;
      if (dwait[c]) begin if (dload[c] != 0) lz = 0; end else lows++;
    end
    chk("waiting_loads_zero", lz, 1);
    if (lows > 1) chk("single_done", lows, 1);
    for (int ch = 0; ch < 4; ch++) begin
      core = ch >> 1;
      isd  = (ch % 2 == 1);
      w    = isd ? dwait[core] : iwait[core];
      if (!w) begin
        if (sb.size() == 0) chk("unexpected_done", ch, 99);
        else begin
          e = sb.pop_front();
          chk("grant_order", ch, e.ch);
          chk("load_data", isd ? dload[core] : iload[core], addr_of(ch) ^ LOAD_KEY);
          chk("ramaddr", ramaddr, addr_of(ch));
          chk("ramWEN", ramWEN, e.wr);
          if (e.wr) chk("ramstore", ramstore, store_of(core));
        end
        if (isd) begin drp[core] = 1'b0; dwp[core] = 1'b0; end
        else ip[core] = 1'b0;
      end
    end
  endtask

  // One clock: drive requests after the edge, respond as the RAM, then sample.
  task automatic step();
    @(posedge CLK); #1;
    iREN = ip; dREN = drp; dWEN = dwp;
    #1;
    if (ramREN || ramWEN) begin
      if (cnt >= ram_lat) begin
        ramstate = ACCESS; ramload = ramaddr ^ LOAD_KEY; cnt = 0;
      end else begin
        ramstate = ram_err ? ERROR : BUSY; ramload = '1; cnt++;
      end
    end else begin
      ramstate = FREE; ramload = '1; cnt = 0;
    end
    @(negedge CLK);
    monitor();
  endtask

  task automatic run_entry(input vec_t v);
    int  steps, ch;
    sb_t e;
    ip = v.ireq; drp = v.dren; dwp = v.dwen; ram_lat = v.lat; ram_err = v.err;
    for (int k = 0; k < v.n; k++) begin
      ch   = int'(v.ord[k]);
      e.ch = ch;
      e.wr = (ch % 2 == 1) && v.dwen[ch >> 1];
      sb.push_back(e);
    end
    steps = 0;
    while (sb.size() != 0 && steps < 200) begin
      step();
      steps++;
    end
    chk("drain", sb.size(), 0);
    chk("txn_cycles", steps, v.n * (2 + v.lat));
    if (sb.size() != 0) begin
      sb.delete(); ip = '0; drp = '0; dwp = '0;
      repeat (3) step();
    end
  endtask

  initial begin
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0;
    ramstate = FREE; ramload = '0;
    for (int c = 0; c < 2; c++) begin
      iaddr[c]  = addr_of(2 * c);
      daddr[c]  = addr_of(2 * c + 1);
      dstore[c] = store_of(c);
    end

    // Expected orders follow rr_ptr carried across entries (starts at 0).
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 3, 0, 1, 0, 0, 0, 0)); // I0, ptr->1
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 0, 0, 2, 1, 0, 0, 0)); // D0 before I0
    tbl.push_back(mk(2'b00, 2'b00, 2'b11, 0, 0, 2, 3, 1, 0, 0)); // writes alternate
    tbl.push_back(mk(2'b11, 2'b11, 2'b00, 1, 0, 4, 3, 1, 2, 0)); // all four
    tbl.push_back(mk(2'b00, 2'b01, 2'b01, 2, 0, 1, 1, 0, 0, 0)); // REN+WEN = write
    tbl.push_back(mk(2'b10, 2'b00, 2'b01, 0, 0, 2, 2, 1, 0, 0)); // core1 I first
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2, 1, 1, 0, 0, 0, 0)); // ERROR retried
    tbl.push_back(mk(2'b00, 2'b10, 2'b00, 0, 0, 1, 3, 0, 0, 0)); // ptr->0
    tbl.push_back(mk(2'b01, 2'b10, 2'b00, 0, 0, 2, 0, 3, 0, 0)); // ptr0: I0 then D1
    tbl.push_back(mk(2'b10, 2'b01, 2'b00, 1, 0, 2, 1, 2, 0, 0)); // D0 then I1
    tbl.push_back(mk(2'b00, 2'b01, 2'b00, 0, 0, 1, 1, 0, 0, 0)); // ptr->1

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_strobes", {ramREN, ramWEN}, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_loads", {iload, dload}, 0);
    RST = 1'b0;

    foreach (tbl[i]) run_entry(tbl[i]);

    // Abort: core1 read granted with ptr=1, dropped mid-BUSY.
    drp = 2'b10; ram_lat = 10; ram_err = 0;
    step();
    step();
    chk("abort_ramREN_on", ramREN, 1);
    chk("abort_addr", ramaddr, addr_of(3));
    step();
    drp = 2'b00;
    step();
    step();
    chk("abort_ramREN_off", {ramREN, ramWEN}, 0);
    chk("abort_dwait", dwait, 2'b11);
    // ptr must still be 1: core1 first.
    run_entry(mk(2'b00, 2'b11, 2'b00, 0, 0, 2, 3, 1, 0, 0));

    // Reset mid-SERVE on a core0 write (ptr=1 beforehand).
    dwp = 2'b01; ram_lat = 10;
    repeat (3) step();
    chk("rst_pre_ramWEN", ramWEN, 1);
    #2 RST = 1'b1;
    #1;
    chk("rst_async_ramWEN", ramWEN, 0);
    chk("rst_async_ramREN", ramREN, 0);
    chk("rst_async_waits", {iwait, dwait}, 4'hF);
    chk("rst_async_ramaddr", ramaddr, 0);
    dwp = '0; iREN = '0; dREN = '0; dWEN = '0; cnt = 0; sb.delete();
    @(posedge CLK); #2;
    RST = 1'b0;
    // ptr reset to 0: core0 first.
    run_entry(mk(2'b00, 2'b11, 2'b00, 0, 0, 2, 1, 3, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
